force_arb_ctrl: RTL

FORCE_ARB_CTRL -- requirements
Module: force_arb_ctrl

---
 rtl/force_arb_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/force_arb_ctrl.sv
// rtl/force_arb_ctrl.sv - two-requester round-robin arbiter over forceable signal slots
module force_arb_ctrl #(
  parameter int WIDTH = 32,
  parameter int NSIG  = 4,
  parameter int IDXW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_a_valid,
  output logic                    req_a_ready,
  input  logic [1:0]              req_a_op,
  input  logic [IDXW-1:0]         req_a_idx,
  input  logic [WIDTH-1:0]        req_a_mask,
  input  logic [WIDTH-1:0]        req_a_value,

  input  logic                    req_b_valid,
  output logic                    req_b_ready,
  input  logic [1:0]              req_b_op,
  input  logic [IDXW-1:0]         req_b_idx,
  input  logic [WIDTH-1:0]        req_b_mask,
  input  logic [WIDTH-1:0]        req_b_value,

  output logic                    rsp_a_valid,
  input  logic                    rsp_a_ready,
  output logic [WIDTH-1:0]        rsp_a_data,
  output logic                    rsp_a_err,

  output logic                    rsp_b_valid,
  input  logic                    rsp_b_ready,
  output logic [WIDTH-1:0]        rsp_b_data,
  output logic                    rsp_b_err,

  input  logic [NSIG*WIDTH-1:0]   drv_in,
  output logic [NSIG*WIDTH-1:0]   eff_out,
  output logic [NSIG*WIDTH-1:0]   frc_en
);

  localparam logic [1:0] OP_FORCE       = 2'b00;
  localparam logic [1:0] OP_RELEASE     = 2'b01;
  localparam logic [1:0] OP_RELEASE_ALL = 2'b10;
  localparam logic [1:0] OP_READ        = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                 state;
  logic                   last_b;   // 1: requester b holds the last grant
  logic                   cur_b;    // requester owning the in-flight request
  logic [1:0]             op_q;
  logic [IDXW-1:0]        idx_q;
  logic [WIDTH-1:0]       mask_q;
  logic [WIDTH-1:0]       value_q;

  logic [NSIG*WIDTH-1:0]  fen;
  logic [NSIG*WIDTH-1:0]  fval;
  logic [NSIG*WIDTH-1:0]  fen_nxt;
  logic [NSIG*WIDTH-1:0]  fval_nxt;
  logic [WIDTH-1:0]       rsp_data_nxt;
  logic                   rsp_err_nxt;

  logic                   grant_a;
  logic                   grant_b;
  logic [31:0]            idx_ext;
  logic                   idx_ok;

  // Forced bits take the force value, all others pass drv_in straight through
  assign eff_out = (fen & fval) | (~fen & drv_in);
  assign frc_en  = fen;

  // Round-robin: on a tie the requester that did not win last time goes first
  assign grant_a     = (state == S_IDLE) && req_a_valid && (!req_b_valid || last_b);
  assign grant_b     = (state == S_IDLE) && req_b_valid && !grant_a;
  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  assign idx_ext = 32'(idx_q);
  assign idx_ok  = idx_ext < 32'(NSIG);

  // Post-update force state and response word for the latched request
  always_comb begin
    fen_nxt      = fen;
    fval_nxt     = fval;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    if (op_q == OP_RELEASE_ALL) begin
      fen_nxt = '0;
    end else if (!idx_ok) begin
      rsp_err_nxt = 1'b1;
    end else begin
      for (int k = 0; k < NSIG; k++) begin
        if (idx_ext == 32'(k)) begin
          case (op_q)
            OP_FORCE: begin
              fen_nxt[k*WIDTH +: WIDTH]  = fen[k*WIDTH +: WIDTH] | mask_q;
              fval_nxt[k*WIDTH +: WIDTH] = (fval[k*WIDTH +: WIDTH] & ~mask_q)
                                         | (value_q & mask_q);
            end
            OP_RELEASE: begin
              fen_nxt[k*WIDTH +: WIDTH] = fen[k*WIDTH +: WIDTH] & ~mask_q;
            end
            OP_READ, OP_RELEASE_ALL: begin
            end
          endcase
          rsp_data_nxt = (fen_nxt[k*WIDTH +: WIDTH] & fval_nxt[k*WIDTH +: WIDTH])
                       | (~fen_nxt[k*WIDTH +: WIDTH] & drv_in[k*WIDTH +: WIDTH]);
        end
      end
    end
  end

  // Request FSM: grant and latch, apply one cycle, hold response until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_b      <= 1'b1;
      cur_b       <= 1'b0;
      op_q        <= OP_FORCE;
      idx_q       <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      fen         <= '0;
      fval        <= '0;
      rsp_a_valid <= 1'b0;
      rsp_a_data  <= '0;
      rsp_a_err   <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_b_data  <= '0;
      rsp_b_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            cur_b   <= grant_b;
            last_b  <= grant_b;
            op_q    <= grant_b ? req_b_op    : req_a_op;
            idx_q   <= grant_b ? req_b_idx   : req_a_idx;
            mask_q  <= grant_b ? req_b_mask  : req_a_mask;
            value_q <= grant_b ? req_b_value : req_a_value;
            state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          fen  <= fen_nxt;
          fval <= fval_nxt;
          if (cur_b) begin
            rsp_b_valid <= 1'b1;
            rsp_b_data  <= rsp_data_nxt;
            rsp_b_err   <= rsp_err_nxt;
          end else begin
            rsp_a_valid <= 1'b1;
            rsp_a_data  <= rsp_data_nxt;
            rsp_a_err   <= rsp_err_nxt;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if ((rsp_a_valid && rsp_a_ready) || (rsp_b_valid && rsp_b_ready)) begin
            rsp_a_valid <= 1'b0;
            rsp_a_data  <= '0;
            rsp_a_err   <= 1'b0;
            rsp_b_valid <= 1'b0;
            rsp_b_data  <= '0;
            rsp_b_err   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
